interlock_card_gen: RTL and testbench

Parametrised next-generation RF-station interlock card. It aggregates N_CH power-supply/driver fault controls into a latched, debounced summary alarm with first-fault capture. It also generates the anode-overcurrent flag, choosing between the low and high current thresholds from an internally delayed tune-not-OK signal, and passes a synchronised emergency input. It sits between the raw supply-control inputs and the station permit/trip logic.

---
 rtl/interlock_pkg.sv | 12 +
 rtl/chan_debounce.sv | 46 ++++
 rtl/interlock_card_gen.sv | 126 ++++++++++++
 tb/tb_interlock_card_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/interlock_pkg.sv
// Shared defaults, index type and fault-mode constants for the RF-station interlock card.
package interlock_pkg;
  localparam int N_CH_DEF       = 6;
  localparam int DEBOUNCE_DEF   = 4;
  localparam int TUNE_DELAY_DEF = 16;
  localparam int FAULT_IDX_W    = $clog2(N_CH_DEF);

  typedef logic [FAULT_IDX_W-1:0] fault_idx_t;

  localparam bit LATCH       = 1'b1;
  localparam bit TRANSPARENT = 1'b0;
endpackage

// File: rtl/chan_debounce.sv
// Two-flop synchroniser followed by a symmetric run-length debouncer for one raw input.
module chan_debounce
  import interlock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = raw_i;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = '0;
    // The final agreeing sample flips the state instead of bumping the count.
    if (s2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = ~deb_q;
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;
endmodule

// File: rtl/interlock_card_gen.sv
// RF-station interlock card: debounced, latched fault summary with first-fault capture,
// tune-delayed anode overcurrent threshold selection and a synchronised emergency input.
module interlock_card_gen
  import interlock_pkg::*;
#(
  parameter int N_CH            = N_CH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int TUNE_DELAY      = TUNE_DELAY_DEF,
  parameter bit LATCH_MODE      = LATCH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_Not_TUNE_OK,
  input  logic                    i_I_AN_LOW_THR,
  input  logic                    i_I_AN_HIGH_THR,
  input  logic                    i_External,
  input  logic [N_CH-1:0]         i_Control,
  input  logic                    i_Clear,
  output logic                    o_I_AN_HIGH,
  output logic                    o_Emergency,
  output logic                    o_Not_Alarm,
  output logic [N_CH-1:0]         o_Fault,
  output logic [$clog2(N_CH)-1:0] o_First_Fault,
  output logic                    o_First_Valid,
  output logic                    o_Clear_Ack
);
  localparam int FW = $clog2(N_CH);
  localparam int TW = $clog2(TUNE_DELAY + 1);

  // Misc synchroniser bit order: {external, high_thr, low_thr, not_tune_ok}.
  logic [3:0]      ms1_q, ms1_d, ms2_q, ms2_d;
  logic [N_CH-1:0] deb;
  logic            clr_deb;
  logic            clr_prev_q, clr_prev_d;
  logic            clr_acc;
  logic [N_CH-1:0] fault_q, fault_d;
  logic            not_alarm_q, not_alarm_d;
  logic [FW-1:0]   first_q, first_d;
  logic            valid_q, valid_d;
  logic            ack_q, ack_d;
  logic [TW-1:0]   tune_cnt_q, tune_cnt_d;
  logic            tune_dly;
  logic            an_high_q, an_high_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    chan_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst_n(reset_n),
      .raw_i(i_Control[g]),
      .deb_o(deb[g])
    );
  end

  // Single-sample filter: only synchronisation plus one register for edge detection.
  chan_debounce #(.DEBOUNCE_CYCLES(1)) u_clr (
    .clk  (clk),
    .rst_n(reset_n),
    .raw_i(i_Clear),
    .deb_o(clr_deb)
  );

  always_comb begin
    ms1_d      = {i_External, i_I_AN_HIGH_THR, i_I_AN_LOW_THR, i_Not_TUNE_OK};
    ms2_d      = ms1_q;
    clr_prev_d = clr_deb;
    clr_acc    = clr_deb & ~clr_prev_q;
    ack_d      = clr_acc;

    // Set wins over clear: a channel still asserted keeps its bit.
    if (LATCH_MODE) fault_d = deb | (fault_q & ~{N_CH{clr_acc}});
    else            fault_d = deb;
    not_alarm_d = ~|fault_d;

    first_d = first_q;
    valid_d = valid_q;
    if (fault_d == '0) begin
      valid_d = 1'b0;
    end else if (!valid_q) begin
      valid_d = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (fault_d[i]) first_d = FW'(i);
      end
    end

    tune_dly = (tune_cnt_q == TW'(TUNE_DELAY));
    if (!ms2_q[0])     tune_cnt_d = '0;
    else if (tune_dly) tune_cnt_d = tune_cnt_q;
    else               tune_cnt_d = tune_cnt_q + 1'b1;

    an_high_d = ~(tune_dly ? ms2_q[1] : ms2_q[2]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms1_q       <= '0;
      ms2_q       <= '0;
      clr_prev_q  <= 1'b0;
      fault_q     <= '0;
      not_alarm_q <= 1'b1;
      first_q     <= '0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      tune_cnt_q  <= '0;
      an_high_q   <= 1'b1;
    end else begin
      ms1_q       <= ms1_d;
      ms2_q       <= ms2_d;
      clr_prev_q  <= clr_prev_d;
      fault_q     <= fault_d;
      not_alarm_q <= not_alarm_d;
      first_q     <= first_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      tune_cnt_q  <= tune_cnt_d;
      an_high_q   <= an_high_d;
    end
  end

  assign o_I_AN_HIGH   = an_high_q;
  assign o_Emergency   = ms2_q[3];
  assign o_Not_Alarm   = not_alarm_q;
  assign o_Fault       = fault_q;
  assign o_First_Fault = first_q;
  assign o_First_Valid = valid_q;
  assign o_Clear_Ack   = ack_q;
endmodule

// File: tb/tb_interlock_card_gen.sv
// Directed bench for interlock_card_gen: a latching instance and a transparent instance share stimulus.
module tb_interlock_card_gen;
  localparam int N  = 6;
  localparam int FW = 3;
  localparam logic [13:0] RST_VAL = {1'b1, 1'b0, 1'b1, 6'b0, 3'b0, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          reset_n, tune, low, high, ext, clr;
  logic [N-1:0]  ctrl;

  logic          a_an, a_em, a_na, a_valid, a_ack;
  logic [N-1:0]  a_fault;
  logic [FW-1:0] a_first;
  logic          b_an, b_em, b_na, b_valid, b_ack;
  logic [N-1:0]  b_fault;
  logic [FW-1:0] b_first;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interlock_card_gen #(.N_CH(N), .DEBOUNCE_CYCLES(4), .TUNE_DELAY(16), .LATCH_MODE(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_Not_TUNE_OK(tune), .i_I_AN_LOW_THR(low),
    .i_I_AN_HIGH_THR(high), .i_External(ext), .i_Control(ctrl), .i_Clear(clr),
    .o_I_AN_HIGH(a_an), .o_Emergency(a_em), .o_Not_Alarm(a_na), .o_Fault(a_fault),
    .o_First_Fault(a_first), .o_First_Valid(a_valid), .o_Clear_Ack(a_ack)
  );

  interlock_card_gen #(.N_CH(N), .DEBOUNCE_CYCLES(4), .TUNE_DELAY(16), .LATCH_MODE(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_Not_TUNE_OK(tune), .i_I_AN_LOW_THR(low),
    .i_I_AN_HIGH_THR(high), .i_External(ext), .i_Control(ctrl), .i_Clear(clr),
    .o_I_AN_HIGH(b_an), .o_Emergency(b_em), .o_Not_Alarm(b_na), .o_Fault(b_fault),
    .o_First_Fault(b_first), .o_First_Valid(b_valid), .o_Clear_Ack(b_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] pack_a();
    return {a_an, a_em, a_na, a_fault, a_first, a_valid, a_ack};
  endfunction

  function automatic logic [13:0] pack_b();
    return {b_an, b_em, b_na, b_fault, b_first, b_valid, b_ack};
  endfunction

  initial begin
    // clock/reset block
    reset_n = 1'b1; tune = 1'b0; low = 1'b0; high = 1'b0; ext = 1'b0; clr = 1'b0; ctrl = '0;
    #1 reset_n = 1'b0;
    #1;
    check_val("reset_async_a", 32'(pack_a()), 32'(RST_VAL));
    check_val("reset_async_b", 32'(pack_b()), 32'(RST_VAL));
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check_val("idle_a", 32'(pack_a()), 32'(RST_VAL));
      check_val("idle_b", 32'(pack_b()), 32'(RST_VAL));
    end

    // emergency: two-edge latency, no debounce
    ext = 1'b1;
    step(1); check_val("emerg_k",  32'(a_em), 32'd0);
    step(1); check_val("emerg_k1", 32'(a_em), 32'd1);
    ext = 1'b0;
    step(2); check_val("emerg_off", 32'(a_em), 32'd0);

    // channel 3 rise: fault at k+6
    ctrl = 6'b001000;
    step(6);
    check_val("ch3_k5_a", 32'(a_fault), 32'h00);
    check_val("ch3_k5_b", 32'(b_fault), 32'h00);
    step(1);
    check_val("ch3_fault_a", 32'(a_fault), 32'h08);
    check_val("ch3_na_a",    32'(a_na),    32'd0);
    check_val("ch3_first_a", 32'(a_first), 32'd3);
    check_val("ch3_valid_a", 32'(a_valid), 32'd1);
    check_val("ch3_fault_b", 32'(b_fault), 32'h08);
    check_val("ch3_first_b", 32'(b_first), 32'd3);

    // 3-cycle glitch on channel 2 is filtered
    ctrl = 6'b001100;
    step(3);
    ctrl = 6'b001000;
    step(8);
    check_val("glitch_a", 32'(a_fault), 32'h08);
    check_val("glitch_b", 32'(b_fault), 32'h08);

    // clear while the input is still high: ack only
    clr = 1'b1;
    step(3); check_val("clr1_noack_early", 32'(a_ack), 32'd0);
    step(1);
    check_val("clr1_ack_a",   32'(a_ack),   32'd1);
    check_val("clr1_ack_b",   32'(b_ack),   32'd1);
    check_val("clr1_fault_a", 32'(a_fault), 32'h08);
    check_val("clr1_valid_a", 32'(a_valid), 32'd1);
    step(1); check_val("clr1_ack_pulse", 32'(a_ack), 32'd0);
    step(5); check_val("clr1_held_noack", 32'(a_ack), 32'd0);
    clr = 1'b0;

    // drop input: latched stays, transparent falls
    ctrl = '0;
    step(7);
    check_val("drop_fault_a", 32'(a_fault), 32'h08);
    check_val("drop_fault_b", 32'(b_fault), 32'h00);
    check_val("drop_valid_b", 32'(b_valid), 32'd0);
    check_val("drop_na_b",    32'(b_na),    32'd1);

    clr = 1'b1;
    step(4);
    check_val("clr2_ack_a",   32'(a_ack),   32'd1);
    check_val("clr2_fault_a", 32'(a_fault), 32'h00);
    check_val("clr2_na_a",    32'(a_na),    32'd1);
    check_val("clr2_valid_a", 32'(a_valid), 32'd0);
    clr = 1'b0;

    // simultaneous rise of channels 4 and 1, then channel 0
    ctrl = 6'b010010;
    step(7);
    check_val("dual_fault_a", 32'(a_fault), 32'h12);
    check_val("dual_first_a", 32'(a_first), 32'd1);
    check_val("dual_valid_a", 32'(a_valid), 32'd1);
    check_val("dual_first_b", 32'(b_first), 32'd1);
    ctrl = 6'b010011;
    step(7);
    check_val("ch0_fault_a", 32'(a_fault), 32'h13);
    check_val("ch0_first_a", 32'(a_first), 32'd1);
    check_val("ch0_first_b", 32'(b_first), 32'd1);

    // transparent instance falls after the debounce; latched holds
    ctrl = '0;
    step(6);
    check_val("fall_k5_b", 32'(b_fault), 32'h13);
    step(1);
    check_val("fall_k6_b",    32'(b_fault), 32'h00);
    check_val("fall_valid_b", 32'(b_valid), 32'd0);
    check_val("fall_na_b",    32'(b_na),    32'd1);
    check_val("fall_fault_a", 32'(a_fault), 32'h13);
    check_val("fall_na_a",    32'(a_na),    32'd0);

    // anode flag with tune OK: HIGH threshold selected
    high = 1'b1;
    step(2); check_val("an_high_k1", 32'(a_an), 32'd1);
    step(1); check_val("an_high_k2", 32'(a_an), 32'd0);
    high = 1'b0;
    step(3); check_val("an_high_rel", 32'(a_an), 32'd1);

    // tune-not-OK delay: LOW threshold selected after 16 counted cycles
    tune = 1'b1; low = 1'b1;
    step(18);
    check_val("tune_k17_a", 32'(a_an), 32'd1);
    check_val("tune_k17_b", 32'(b_an), 32'd1);
    step(1);
    check_val("tune_k18_a", 32'(a_an), 32'd0);
    check_val("tune_k18_b", 32'(b_an), 32'd0);
    high = 1'b1;
    step(3); check_val("tune_low_sel", 32'(a_an), 32'd0);
    high = 1'b0; tune = 1'b0;
    step(3); check_val("tune_rel_k2", 32'(a_an), 32'd0);
    step(1); check_val("tune_rel_k3", 32'(a_an), 32'd1);
    low = 1'b0;

    // async reset mid-fault, then re-debounce from zero
    ctrl = 6'b000100;
    step(7);
    check_val("pre_rst_b", 32'(b_fault), 32'h04);
    check_val("pre_rst_a", 32'(a_fault), 32'h17);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_rst_a", 32'(pack_a()), 32'(RST_VAL));
    check_val("mid_rst_b", 32'(pack_b()), 32'(RST_VAL));
    #1 reset_n = 1'b1;
    step(6);
    check_val("rdeb_k5_a", 32'(a_fault), 32'h00);
    check_val("rdeb_k5_b", 32'(b_fault), 32'h00);
    step(1);
    check_val("rdeb_k6_a",     32'(a_fault), 32'h04);
    check_val("rdeb_k6_b",     32'(b_fault), 32'h04);
    check_val("rdeb_first_a",  32'(a_first), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
